// File: rtl/hadamard_satd_8x8.sv
// hadamard_satd_8x8: 8x8 2-D Hadamard SATD, row pass on entry, column pass over a transpose buffer.
module hadamard8 #(
   parameter int W = 9
) (
   input  logic [8*W-1:0]     i_x,
   output logic [8*(W+3)-1:0] o_y
);
   logic signed [W+2:0] w_s [4][8];
   for (genvar n = 0; n < 8; n++) begin : g_io
      assign w_s[0][n] = (W+3)'($signed(i_x[n*W+:W]));
      assign o_y[n*(W+3)+:(W+3)] = w_s[3][n];
   end
   // stage t pairs (L, L+S) with S = 4, 2, 1 giving Sylvester order
   for (genvar t = 0; t < 3; t++) begin : g_st
      for (genvar i = 0; i < 4; i++) begin : g_bf
         localparam int S = 4 >> t;
         localparam int L = (i / S) * 2 * S + i % S;
         assign w_s[t+1][L]   = w_s[t][L] + w_s[t][L+S];
         assign w_s[t+1][L+S] = w_s[t][L] - w_s[t][L+S];
      end
   end
endmodule

module hadamard_satd_8x8 #(
   parameter int IN_W   = 9,
   parameter int SATD_W = 20
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [IN_W-1:0] diff_0,
   input  logic signed [IN_W-1:0] diff_1,
   input  logic signed [IN_W-1:0] diff_2,
   input  logic signed [IN_W-1:0] diff_3,
   input  logic signed [IN_W-1:0] diff_4,
   input  logic signed [IN_W-1:0] diff_5,
   input  logic signed [IN_W-1:0] diff_6,
   input  logic signed [IN_W-1:0] diff_7,
   output logic [SATD_W-1:0]      satd,
   output logic                   satd_valid
);
   localparam int RW = IN_W + 3;
   localparam int CW = IN_W + 6;
   localparam logic S_FILL = 1'b0;
   localparam logic S_COL  = 1'b1;

   logic              r_state;
   logic [2:0]        r_row, r_col;
   logic [SATD_W-1:0] r_acc;
   logic [RW-1:0]     r_buf [8][8];
   logic [8*IN_W-1:0] w_din;
   logic [8*RW-1:0]   w_rowh, w_colin;
   logic [8*CW-1:0]   w_colh;
   logic [CW-1:0]     w_abs [8];
   logic [SATD_W-1:0] w_sum;
   logic              w_xfer;

   assign w_din    = {diff_7, diff_6, diff_5, diff_4, diff_3, diff_2, diff_1, diff_0};
   assign in_ready = r_state == S_FILL;
   assign w_xfer   = in_valid && in_ready;

   hadamard8 #(.W(IN_W)) u_row (.i_x(w_din),   .o_y(w_rowh));
   hadamard8 #(.W(RW))   u_col (.i_x(w_colin), .o_y(w_colh));

   for (genvar n = 0; n < 8; n++) begin : g_col
      assign w_colin[n*RW+:RW] = r_buf[n][r_col];
      assign w_abs[n] = w_colh[n*CW+CW-1] ? -w_colh[n*CW+:CW] : w_colh[n*CW+:CW];
   end

   always_comb begin
      w_sum = '0;
      for (int k = 0; k < 8; k++) w_sum = w_sum + SATD_W'(w_abs[k]);
   end

   always_ff @(posedge clk) begin
      if (w_xfer) for (int k = 0; k < 8; k++) r_buf[r_row][k] <= w_rowh[k*RW+:RW];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_FILL;
         r_row      <= '0;
         r_col      <= '0;
         r_acc      <= '0;
         satd       <= '0;
         satd_valid <= 1'b0;
      end else begin
         satd_valid <= 1'b0;
         if (r_state == S_FILL) begin
            if (in_valid) begin
               r_row <= r_row + 3'd1;
               if (r_row == 3'd7) begin
                  r_col   <= '0;
                  r_acc   <= '0;
                  r_state <= S_COL;
               end
            end
         end else begin
            r_acc <= r_acc + w_sum;
            r_col <= r_col + 3'd1;
            if (r_col == 3'd7) begin
               satd       <= r_acc + w_sum;
               satd_valid <= 1'b1;
               r_state    <= S_FILL;
            end
         end
      end
   end
endmodule

// File: tb/tb_hadamard_satd_8x8.sv
// tb_hadamard_satd_8x8: randomized and directed checks of hadamard_satd_8x8 against a matrix-form SATD model.
module tb_hadamard_satd_8x8;
   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic signed [8:0] d [8];
   logic              in_ready, satd_valid;
   logic [19:0]       satd;

   int tests = 0, fails = 0, cyc = 0, lowcnt = 0;
   int blk [4][8][8];
   int acc [32];
   int pc[$], pv[$];

   hadamard_satd_8x8 dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .diff_0(d[0]), .diff_1(d[1]), .diff_2(d[2]), .diff_3(d[3]),
      .diff_4(d[4]), .diff_5(d[5]), .diff_6(d[6]), .diff_7(d[7]),
      .satd(satd), .satd_valid(satd_valid)
   );

   always #5 clk = ~clk;

   function automatic int model(input int b);
      int tot = 0;
      for (int u = 0; u < 8; u++)
         for (int v = 0; v < 8; v++) begin
            int s = 0;
            for (int r = 0; r < 8; r++)
               for (int c = 0; c < 8; c++)
                  s += ((($countones(u & r) + $countones(v & c)) % 2) != 0) ? -blk[b][r][c] : blk[b][r][c];
            tot += (s < 0) ? -s : s;
         end
      return tot;
   endfunction

   function automatic void fill(input int b, input int val, input bit alt);
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) blk[b][r][c] = (alt && (c % 2 == 1)) ? -val : val;
   endfunction

   task automatic drive(input int nrows, input int gap);
      int idx = 0, idle = 0, tail = 0;
      pc.delete();
      pv.delete();
      lowcnt = 0;
      for (int t = 0; t < 3000 && tail < 12; t++) begin
         bit v, r;
         v = (idx < nrows) && (idle == 0);
         in_valid = v;
         if (v) for (int n = 0; n < 8; n++) d[n] = 9'(blk[idx/8][idx%8][n]);
         r = in_ready;
         if (satd_valid) begin
            pc.push_back(cyc);
            pv.push_back(int'(satd));
         end
         if (!in_ready) lowcnt++;
         @(negedge clk);
         cyc++;
         if (v && r) begin
            acc[idx] = cyc;
            idx++;
            idle = gap;
         end else if (idle > 0) idle--;
         if (idx == nrows) tail++;
      end
      in_valid = 1'b0;
      tests++;
      if (idx != nrows) begin
         fails++;
         $display("FAIL drive_timeout: accepted %0d rows, required %0d", idx, nrows);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (in_ready !== 1'b1 || satd_valid !== 1'b0 || satd !== 20'd0) begin
         fails++;
         $display("FAIL reset_state: in_ready=%b satd_valid=%b satd=%0d, required 1 0 0", in_ready, satd_valid, satd);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_zeros();
      fill(0, 0, 0);
      drive(8, 0);
      tests++;
      if (pc.size() != 1) begin
         fails++;
         $display("FAIL zeros_pulses: got %0d pulses, required 1", pc.size());
      end else begin
         tests += 2;
         if (pc[0] != acc[7] + 8) begin
            fails++;
            $display("FAIL zeros_latency: got %0d cycles, required 8", pc[0] - acc[7]);
         end
         if (pv[0] != 0) begin
            fails++;
            $display("FAIL zeros_satd: got %0d, required 0", pv[0]);
         end
      end
      tests++;
      if (lowcnt != 8) begin
         fails++;
         $display("FAIL zeros_ready_low: got %0d cycles, required 8", lowcnt);
      end
   endtask

   task automatic test_value(input string name, input int val, input bit alt, input int gap, input int exp);
      fill(0, val, alt);
      if (name == "impulse") begin
         fill(0, 0, 0);
         blk[0][0][0] = 5;
      end
      drive(8, gap);
      tests++;
      if (pc.size() != 1) begin
         fails++;
         $display("FAIL %s_pulses: got %0d pulses, required 1", name, pc.size());
      end else begin
         tests++;
         if (pv[0] != exp) begin
            fails++;
            $display("FAIL %s_satd: got %0d, required %0d", name, pv[0], exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      fill(0, 0, 0);
      fill(1, 1, 0);
      drive(16, 0);
      tests++;
      if (pc.size() != 2) begin
         fails++;
         $display("FAIL b2b_pulses: got %0d pulses, required 2", pc.size());
      end else begin
         tests += 4;
         if (pv[0] != 0 || pv[1] != 64) begin
            fails++;
            $display("FAIL b2b_satd: got %0d,%0d, required 0,64", pv[0], pv[1]);
         end
         if (acc[8] != pc[0] + 1) begin
            fails++;
            $display("FAIL b2b_row0_accept: accepted %0d cycles after pulse, required in pulse cycle", acc[8] - pc[0] - 1);
         end
         if (pc[1] != pc[0] + 16) begin
            fails++;
            $display("FAIL b2b_spacing: got %0d cycles, required 16", pc[1] - pc[0]);
         end
         if (lowcnt != 16) begin
            fails++;
            $display("FAIL b2b_ready_low: got %0d cycles, required 16", lowcnt);
         end
      end
   endtask

   task automatic test_reset_abort();
      fill(0, 255, 0);
      drive(4, 0);
      rst = 1'b1;
      @(negedge clk);
      tests++;
      if (satd !== 20'd0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL abort_reset_state: satd=%0d in_ready=%b, required 0 1", satd, in_ready);
      end
      rst = 1'b0;
      fill(0, 1, 0);
      drive(8, 0);
      tests++;
      if (pc.size() != 1 || pv[0] != 64) begin
         fails++;
         $display("FAIL abort_result: got %0d pulses first=%0d, required 1 pulse of 64", pc.size(), pc.size() > 0 ? pv[0] : -1);
      end
   endtask

   task automatic test_random();
      int g, exp;
      for (int b = 0; b < 3; b++)
         for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) blk[b][r][c] = int'($urandom_range(510, 0)) - 255;
      g = int'($urandom_range(1, 0));
      drive(24, g);
      tests++;
      if (pc.size() != 3) begin
         fails++;
         $display("FAIL random_pulses: got %0d pulses, required 3", pc.size());
      end else begin
         for (int b = 0; b < 3; b++) begin
            exp = model(b);
            tests++;
            if (pv[b] != exp) begin
               fails++;
               $display("FAIL random_satd_%0d: got %0d, required %0d", b, pv[b], exp);
            end
         end
      end
   endtask

   initial begin
      for (int n = 0; n < 8; n++) d[n] = '0;
      test_reset();
      test_zeros();
      test_value("impulse", 0, 0, 0, 320);
      test_value("dc_pos", 1, 0, 0, 64);
      test_value("dc_neg", -255, 0, 0, 16320);
      test_value("alternating", 255, 1, 2, 16320);
      test_back_to_back();
      test_reset_abort();
      for (int k = 0; k < 3; k++) test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/hadamard_satd_8x8.md
Name: hadamard_satd_8x8

Overview:
- Downstream consumer of the per-row residual stage. Takes eight rows of eight signed 9-bit original-minus-current differences, one row per accepted transfer.
- Applies an 8x8 2-D Hadamard transform: a row pass on entry, then a column pass over a transpose buffer.
- Accumulates the absolute value of all 64 coefficients and emits one SATD value per 8x8 block with a one-cycle valid pulse.

Parameters:
- IN_W, 9, width of each signed difference input.
- SATD_W, 20, width of the unsigned SATD result. Minimum legal value is 17 for IN_W=9.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a row of differences is present on diff_0..diff_7.
- in_ready  output  1  block can accept a row this cycle.
- diff_0 .. diff_7  input  IN_W each, signed  differences for columns 0..7 of the current row.
- satd  output  SATD_W, unsigned  sum of |coefficient| over the last completed block.
- satd_valid  output  1  one-cycle pulse; satd is new this cycle.

Behaviour:
- Reset (rst=1 at an edge):
  - state <= FILL; row_cnt, col_cnt <= 0; accumulator <= 0.
  - satd <= 0; satd_valid <= 0.
  - Transpose buffer contents are don't-care.
  - in_ready is 1 in the cycle after reset.
  - Reset mid-block discards all partial rows and the partial sum; no satd_valid is produced for the aborted block.
- Transfer occurs only on an edge where in_valid && in_ready. in_valid may drop between rows; gaps have no effect.
- Transform: Sylvester-ordered 8-point Hadamard, H[k][n] = (-1)^popcount(k&n), with no normalisation. Three butterfly stages pair (i, i+4), then (i, i+2), then (i, i+1). All arithmetic is signed two's complement.
- Widths: row-pass outputs are IN_W+3 = 12 bits; column-pass outputs are IN_W+6 = 15 bits. No truncation or saturation at any point. Absolute values are taken at 15 bits; -16384 is unreachable for IN_W=9.
- State FILL (in_ready=1):
  - Each transfer computes the row Hadamard of diff_0..7 combinationally and writes it to buffer row[row_cnt] on that edge; row_cnt increments.
  - The transfer with row_cnt=7 sets row_cnt <= 0, col_cnt <= 0, accumulator <= 0, state <= COL.
- State COL (in_ready=0, 8 cycles):
  - Each edge reads column col_cnt (eight 12-bit values from rows 0..7), applies the column Hadamard, sums the eight absolute values, and adds the sum to the accumulator.
  - col_cnt increments each edge.
  - On the col_cnt=7 edge: satd <= accumulator + column sum; satd_valid <= 1; state <= FILL.
- satd_valid is high for exactly one cycle, 8 cycles after the edge that accepted row 7. In that same cycle in_ready is 1 again, so the next block's row 0 may be accepted.
- Steady-state throughput is one block per 16 cycles.
- satd holds its value until the next completion or reset.
- SATD_W overflow is unreachable for the legal IN_W/SATD_W combination; no wrap handling is required.

Test Plan:
- Reset, then 8 rows of all-zero diffs with in_valid held high -> satd_valid pulses once, 8 cycles after row 7 is accepted; satd=0; in_ready is 0 for exactly those 8 cycles.
- Row 0 diff_0=5, all other inputs 0 -> every coefficient is ±5, so satd=320.
- All 64 diffs = +1 -> only DC is nonzero (64), so satd=64. Repeat with all = -255 -> satd=16320.
- Column-alternating pattern x[r][c] = 255·(-1)^c for every row, with in_valid deasserted for 2 cycles between each row -> satd=16320; gaps do not change the result or the pulse count.
- Two blocks back-to-back (zeros, then all +1) with in_valid continuously high -> satd=0 pulse, then row 0 of the second block is accepted in the pulse cycle; the next pulse is 16 cycles later with satd=64.
- After 4 rows of +255, assert rst for one cycle, then send 8 rows of all +1 -> no pulse for the aborted block; a single pulse with satd=64.
